// File: rtl/lfsr_pkg.sv
// Shared constants and state encoding for the LFSR decrypt / depad engine.
package lfsr_pkg;

    localparam int LFSR_W   = 7;
    localparam int NUM_PTRN = 9;

    localparam logic [LFSR_W-1:0] SPACE = 7'h20;

    // Entry 0 sits in the least significant slot.
    localparam logic [NUM_PTRN-1:0][LFSR_W-1:0] TAP_TABLE = {
        7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60
    };

    typedef enum logic [2:0] {
        IDLE, SEED, PROBE, NEXT, DECODE, FILL, DONE
    } state_t;

endpackage

// File: rtl/lfsr_step.sv
// One Galois-free shift step of the LFSR: shift left, feed back the parity of tapped bits.
module lfsr_step
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] state_i,
    input  logic [LFSR_W-1:0] taps_i,
    output logic [LFSR_W-1:0] next_o
);

    assign next_o = {state_i[LFSR_W-2:0], ^(state_i & taps_i)};

endmodule

// File: rtl/lfsr_decrypt_depad.sv
// Tap search from a space preamble, then decrypt, strip leading spaces and space-fill the
// output region. Single-port DM master; reads are pipelined one address ahead of the data.
module lfsr_decrypt_depad
    import lfsr_pkg::*;
#(
    parameter int MSG_LEN   = 64,
    parameter int SRC_BASE  = 64,
    parameter int DST_BASE  = 0,
    parameter int PROBE_LEN = 10,
    parameter int ADDR_W    = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              ack_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [LFSR_W:0]   mem_rdata_i,
    output logic              mem_wen_o,
    output logic [LFSR_W:0]   mem_wdata_o,
    output logic              ptrn_found_o,
    output logic [3:0]        ptrn_idx_o,
    output logic [6:0]        err_count_o
);

    localparam int CNT_W = $clog2(MSG_LEN + 1);
    localparam logic [ADDR_W-1:0] SRC   = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST   = ADDR_W'(DST_BASE);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(MSG_LEN - 1);
    localparam logic [CNT_W-1:0]  PLAST = CNT_W'(PROBE_LEN - 1);

    state_t             state_q;
    logic               start_q, ack_q, wen_q, found_q;
    logic               skip_q, fetch_q, wr_q, use_buf_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [LFSR_W:0]    wdata_q, buf_q;
    logic [LFSR_W-1:0]  seed_q, s_q, s_nxt;
    logic [3:0]         idx_q, pidx_q, idx_d;
    logic [6:0]         err_q, err_d;
    logic [CNT_W-1:0]   k_q, i_q, j_q;

    function automatic logic [ADDR_W-1:0] src_at(input logic [CNT_W-1:0] n);
        return SRC + ADDR_W'(n);
    endfunction

    function automatic logic [ADDR_W-1:0] dst_at(input logic [CNT_W-1:0] n);
        return DST + ADDR_W'(n);
    endfunction

    // A read that lands during a write cycle is parked in buf_q and replayed next cycle.
    logic [LFSR_W:0]   byte_w;
    logic [LFSR_W-1:0] plain_w;
    logic              err_w;

    assign byte_w  = use_buf_q ? buf_q : mem_rdata_i;
    assign plain_w = byte_w[LFSR_W-1:0] ^ s_q;
    assign err_w   = ^byte_w;
    assign idx_d   = idx_q + 4'd1;
    assign err_d   = (err_q == 7'h7F) ? err_q : err_q + 7'd1;

    lfsr_step u_step (
        .state_i (s_q),
        .taps_i  (TAP_TABLE[idx_q]),
        .next_o  (s_nxt)
    );

    always_ff @(posedge clk_i) begin
        start_q <= start_i;
        if (reset_i) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            wen_q     <= 1'b0;
            found_q   <= 1'b0;
            pidx_q    <= '0;
            err_q     <= '0;
            addr_q    <= SRC;
            fetch_q   <= 1'b0;
            wr_q      <= 1'b0;
            use_buf_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_q && !start_i) begin
                    // DM already sees SRC_BASE this cycle, so byte 0 arrives in SEED.
                    state_q <= SEED;
                    addr_q  <= src_at(CNT_W'(1));
                    found_q <= 1'b0;
                    pidx_q  <= '0;
                    err_q   <= '0;
                    ack_q   <= 1'b0;
                end
                SEED: begin
                    seed_q  <= mem_rdata_i[LFSR_W-1:0] ^ SPACE;
                    s_q     <= mem_rdata_i[LFSR_W-1:0] ^ SPACE;
                    idx_q   <= '0;
                    k_q     <= CNT_W'(1);
                    addr_q  <= src_at(CNT_W'(2));
                    state_q <= PROBE;
                end
                PROBE: if ((mem_rdata_i[LFSR_W-1:0] ^ s_nxt) != SPACE) begin
                    state_q <= NEXT;
                    addr_q  <= src_at(CNT_W'(1));
                end else if (k_q == PLAST) begin
                    found_q   <= 1'b1;
                    pidx_q    <= idx_q;
                    addr_q    <= src_at('0);
                    s_q       <= seed_q;
                    fetch_q   <= 1'b1;
                    wr_q      <= 1'b0;
                    skip_q    <= 1'b1;
                    use_buf_q <= 1'b0;
                    i_q       <= '0;
                    j_q       <= '0;
                    state_q   <= DECODE;
                end else begin
                    k_q    <= k_q + CNT_W'(1);
                    s_q    <= s_nxt;
                    addr_q <= src_at(k_q + CNT_W'(2));
                end
                NEXT: if (idx_d == 4'(NUM_PTRN)) begin
                    state_q <= DONE;
                    ack_q   <= 1'b1;
                end else begin
                    idx_q   <= idx_d;
                    s_q     <= seed_q;
                    k_q     <= CNT_W'(1);
                    addr_q  <= src_at(CNT_W'(2));
                    state_q <= PROBE;
                end
                DECODE: if (fetch_q) begin
                    fetch_q <= 1'b0;
                    addr_q  <= src_at(CNT_W'(1));
                end else if (wr_q) begin
                    buf_q     <= mem_rdata_i;
                    use_buf_q <= 1'b1;
                    wr_q      <= 1'b0;
                    wen_q     <= 1'b0;
                    j_q       <= j_q + CNT_W'(1);
                    if (i_q == LAST) begin
                        if (j_q == LAST) begin
                            state_q <= DONE;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= FILL;
                            addr_q  <= dst_at(j_q + CNT_W'(1));
                            wen_q   <= 1'b1;
                            wdata_q <= {1'b0, SPACE};
                        end
                    end else begin
                        i_q    <= i_q + CNT_W'(1);
                        addr_q <= src_at(i_q + CNT_W'(2));
                    end
                end else begin
                    s_q       <= s_nxt;
                    use_buf_q <= 1'b0;
                    if (skip_q && !err_w && plain_w == SPACE) begin
                        i_q    <= i_q + CNT_W'(1);
                        addr_q <= src_at(i_q + CNT_W'(2));
                        if (i_q == LAST) begin
                            state_q <= FILL;
                            addr_q  <= dst_at(j_q);
                            wen_q   <= 1'b1;
                            wdata_q <= {1'b0, SPACE};
                        end
                    end else begin
                        skip_q  <= 1'b0;
                        wr_q    <= 1'b1;
                        wen_q   <= 1'b1;
                        addr_q  <= dst_at(j_q);
                        wdata_q <= {err_w, plain_w};
                        if (err_w) err_q <= err_d;
                    end
                end
                FILL: begin
                    j_q <= j_q + CNT_W'(1);
                    if (j_q == LAST) begin
                        state_q <= DONE;
                        wen_q   <= 1'b0;
                        ack_q   <= 1'b1;
                    end else begin
                        addr_q <= dst_at(j_q + CNT_W'(1));
                    end
                end
                DONE: if (start_i) begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    addr_q  <= SRC;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o        = ack_q;
    assign mem_addr_o   = addr_q;
    assign mem_wen_o    = wen_q;
    assign mem_wdata_o  = wdata_q;
    assign ptrn_found_o = found_q;
    assign ptrn_idx_o   = pidx_q;
    assign err_count_o  = err_q;

endmodule

// File: tb/tb_lfsr_decrypt_depad.sv
// Bench for lfsr_decrypt_depad: DM model, encrypting stimulus generator and a reference
// decoder that works directly from the byte-level rules.
module tb_lfsr_decrypt_depad;

    localparam int MSG = 64;
    localparam int SRC = 64;
    localparam int PL  = 10;

    logic       clk = 1'b0;
    logic       reset, start, ack, wen, found;
    logic [7:0] addr, rdata, wdata;
    logic [3:0] pidx;
    logic [6:0] errc;

    logic       ld_en, cnt_clr;
    logic [7:0] ld_addr, ld_data;
    logic [7:0] dm [256];
    int         wen_cnt;

    int         n_cmp = 0;
    int         n_bad = 0;

    logic [6:0] taps [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
    string      t1_msg = "Mr. Watson, come here. I want to see you.";
    logic [7:0] cip    [MSG];
    logic [7:0] pre_dm [MSG];
    logic [7:0] exp_dm [MSG];
    int         exp_found, exp_idx, exp_err, exp_wr;

    lfsr_decrypt_depad dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .ack_o        (ack),
        .mem_addr_o   (addr),
        .mem_rdata_i  (rdata),
        .mem_wen_o    (wen),
        .mem_wdata_o  (wdata),
        .ptrn_found_o (found),
        .ptrn_idx_o   (pidx),
        .err_count_o  (errc)
    );

    always #5 clk = ~clk;

    // Synchronous-read DM; the bench preloads it through the ld_* side port.
    always @(posedge clk) begin
        rdata <= dm[addr];
        if (ld_en) dm[ld_addr] <= ld_data;
        else if (wen) dm[addr] <= wdata;
        if (cnt_clr) wen_cnt <= 0;
        else if (wen) wen_cnt <= wen_cnt + 1;
    end

    function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // kind 0: the T1 sentence, 1: random text, 2: all spaces
    task automatic gen(input int ti, input logic [6:0] seed, input int pre, input int kind);
        logic [6:0] s, p, c;
        s = seed;
        for (int i = 0; i < MSG; i++) begin
            p = 7'h20;
            if (i >= pre && kind == 0 && (i - pre) < t1_msg.len()) p = t1_msg[i - pre][6:0];
            if (i >= pre && kind == 1) p = ($urandom_range(0, 7) == 0) ? 7'h20 : 7'($urandom_range(33, 126));
            c = p ^ s;
            cip[i] = {^c, c};
            s = step(s, taps[ti]);
        end
    endtask

    task automatic model();
        logic [6:0] seed, s, plain;
        logic       ok, lead, e;
        int         n;
        seed = cip[0][6:0] ^ 7'h20;
        exp_found = 0; exp_idx = 0; exp_err = 0;
        for (int p = 0; p < 9 && exp_found == 0; p++) begin
            s = seed; ok = 1'b1;
            for (int k = 1; k < PL; k++) begin
                s = step(s, taps[p]);
                if ((cip[k][6:0] ^ s) != 7'h20) begin ok = 1'b0; break; end
            end
            if (ok) begin exp_found = 1; exp_idx = p; end
        end
        for (int i = 0; i < MSG; i++) exp_dm[i] = exp_found ? 8'h20 : pre_dm[i];
        exp_wr = exp_found ? MSG : 0;
        if (exp_found == 0) return;
        s = seed; lead = 1'b1; n = 0;
        for (int i = 0; i < MSG; i++) begin
            plain = cip[i][6:0] ^ s;
            e = ^cip[i];
            s = step(s, taps[exp_idx]);
            if (lead && !e && plain == 7'h20) continue;
            lead = 1'b0;
            exp_dm[n] = {e, plain};
            n++;
            if (e) exp_err++;
        end
    endtask

    task automatic load(input int a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = 8'(a); ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic prepare();
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < MSG; i++) load(SRC + i, cip[i]);
        for (int i = 0; i < MSG; i++) begin
            pre_dm[i] = 8'($urandom);
            load(i, pre_dm[i]);
        end
        model();
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic launch_and_check(input string tag);
        int cyc;
        start = 1'b0;
        cyc = 0;
        while (ack !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_ack"}, int'(ack), 1);
        check({tag, "_found"}, int'(found), exp_found);
        check({tag, "_idx"}, int'(pidx), exp_idx);
        check({tag, "_err"}, int'(errc), exp_err);
        check({tag, "_writes"}, wen_cnt, exp_wr);
        for (int i = 0; i < MSG; i++)
            check($sformatf("%s_dm%0d", tag, i), int'(dm[i]), int'(exp_dm[i]));
        start = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        logic [6:0] seeds [3];
        seeds = '{7'h01, 7'h7F, 7'h2A};
        reset = 1'b1; start = 1'b1; ld_en = 1'b0; cnt_clr = 1'b1;
        ld_addr = '0; ld_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", int'(ack), 0);
        check("rst_wen", int'(wen), 0);
        check("rst_found", int'(found), 0);
        check("rst_idx", int'(pidx), 0);
        check("rst_err", int'(errc), 0);
        check("rst_addr", int'(addr), SRC);
        reset = 1'b0; cnt_clr = 1'b0;

        // T1 known sentence, T2 with a parity error in cipher byte 30
        gen(6, 7'h01, 10, 0); prepare(); launch_and_check("T1");
        gen(6, 7'h01, 10, 0); cip[30][2] = ~cip[30][2]; prepare(); launch_and_check("T2");

        // T3 every tap pattern against three seeds, random preamble length and text
        for (int t = 0; t < 9; t++)
            for (int s = 0; s < 3; s++) begin
                gen(t, seeds[s], int'($urandom_range(10, 15)), 1);
                prepare();
                launch_and_check($sformatf("T3_p%0d_s%0d", t, s));
            end

        // T4 no pattern matches: DM untouched
        for (int i = 0; i < MSG; i++) cip[i] = 8'h00;
        prepare(); launch_and_check("T4");

        // T5 message of nothing but spaces
        gen(3, 7'h55, MSG, 2); prepare(); launch_and_check("T5");

        // T6 reset in the middle of DECODE, then a clean rerun
        gen(6, 7'h01, 10, 0); prepare();
        start = 1'b0; cyc = 0;
        while (wen_cnt < 5 && cyc < 3000) begin @(negedge clk); cyc++; end
        check("T6_reached_decode", int'(wen_cnt >= 5), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("T6_wen_after_rst", int'(wen), 0);
        check("T6_ack_after_rst", int'(ack), 0);
        check("T6_found_after_rst", int'(found), 0);
        cnt_clr = 1'b1; @(negedge clk); cnt_clr = 1'b0;
        repeat (20) @(negedge clk);
        check("T6_quiet_after_rst", wen_cnt, 0);
        gen(6, 7'h01, 10, 0); prepare(); launch_and_check("T6_rerun");

        // T7 random pattern/seed with scattered parity errors past the preamble
        for (int r = 0; r < 6; r++) begin
            gen(int'($urandom_range(0, 8)), 7'($urandom_range(1, 127)), int'($urandom_range(10, 20)), 1);
            for (int e = 0; e < int'($urandom_range(1, 3)); e++) begin
                int b;
                b = int'($urandom_range(PL, MSG - 1));
                cip[b] = cip[b] ^ (8'h01 << $urandom_range(0, 7));
            end
            prepare();
            launch_and_check($sformatf("T7_r%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
